// File: rtl/sram_imc_pkg.sv
// Shared definitions for the SRAM in-memory-compute Wishbone controller.
// Holds the controller FSM state encoding, register window offsets and
// the bit positions of the CTRL and STATUS registers.
package sram_imc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDWAIT,
    ST_SETTLE,
    ST_EVAL,
    ST_EVWAIT,
    ST_ACK
  } state_e;

  // adr[16] selects the register window; adr[3:2] picks the register
  localparam int          REG_WIN_BIT = 16;
  localparam logic [1:0]  REG_CTRL    = 2'd0;
  localparam logic [1:0]  REG_STATUS  = 2'd1;
  localparam logic [1:0]  REG_RESULT  = 2'd2;
  localparam logic [1:0]  REG_RSVD    = 2'd3;

  // CTRL fields
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_IREF_LSB = 8;
  localparam int CTRL_ROW_LSB  = 16;

  // STATUS fields
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

endpackage

// File: rtl/sram_imc_settle_cnt.sv
// Settle-time down-counter for the IMC sequence.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   load_i  - reload with the settle length (one cycle before settling starts)
//   en_i    - count down while settling
//   done_o  - high in the last settle cycle
// A settle length of 0 is treated as 1 so the FSM always spends at least
// one cycle with the clamp enabled before evaluating.
module sram_imc_settle_cnt #(
  parameter int SETTLE_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int LOAD_VAL = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int CW       = $clog2(LOAD_VAL + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                    cnt_q <= '0;
    else if (load_i)              cnt_q <= CW'(LOAD_VAL);
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
  end

  assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/sram_imc_wb_ctrl.sv
// Wishbone slave controller for an SRAM in-memory-compute macro.
// Data window (adr[16]=0): plain row writes/reads to the macro.
// Register window (adr[16]=1): CTRL, STATUS, RESULT, reserved.
// A START write kicks off clamp-settle, one evaluation read of the
// CTRL-selected row, and latches the result with a sticky DONE flag.
// Ports:
//   wb_clk_i, wb_rst_i        - clock, synchronous active-high reset
//   wbs_*                     - Wishbone classic slave
//   mem_addr/wdata/we/re      - macro access (rdata valid one cycle after re)
//   mem_rdata                 - macro read data
//   en_vclp, iref_en, imc_irq - analog clamp, Iref enables, completion irq
// Assumes DATA_W <= 32 and DATA_W >= ADDR_W + 16 so every CTRL field fits.
module sram_imc_wb_ctrl
  import sram_imc_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 8,
  parameter int          N_IREF     = 4,
  parameter int          SETTLE_CYC = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              en_vclp,
  output logic [N_IREF-1:0] iref_en,
  output logic              imc_irq
);

  function automatic logic [DATA_W-1:0] ctrl_mask();
    logic [DATA_W-1:0] m;
    m = '0;
    m[CTRL_IRQ_EN] = 1'b1;
    for (int i = 0; i < N_IREF; i++) m[CTRL_IREF_LSB+i] = 1'b1;
    for (int i = 0; i < ADDR_W; i++) m[CTRL_ROW_LSB+i]  = 1'b1;
    return m;
  endfunction

  // START is never stored, so it always reads back as 0
  localparam logic [DATA_W-1:0] CTRL_MASK = ctrl_mask();

  state_e            state_q;
  logic [DATA_W-1:0] ctrl_q, result_q, dat_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              done_q, start_pend_q, ack_q, mem_we_q, mem_re_q, en_vclp_q;

  logic              req, live, is_reg, busy, settle_done;
  logic              done_set, done_clr, done_d;
  logic [1:0]        reg_idx;
  logic [ADDR_W-1:0] row;
  logic [DATA_W-1:0] wmerge, reg_rdata;
  logic              unused_adr;

  assign live       = wbs_cyc_i & wbs_stb_i;
  assign req        = live & (wbs_adr_i[31:20] == BASE_ADDR[31:20]);
  assign is_reg     = wbs_adr_i[REG_WIN_BIT];
  assign reg_idx    = wbs_adr_i[3:2];
  assign row        = wbs_adr_i[ADDR_W+1:2];
  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_EVAL) || (state_q == ST_EVWAIT);
  assign unused_adr = ^wbs_adr_i;

  // Byte lanes not selected are written as zero, not preserved
  always_comb begin
    wmerge = '0;
    for (int b = 0; b < DATA_W/8; b++)
      wmerge[b*8 +: 8] = wbs_sel_i[b] ? wbs_dat_i[b*8 +: 8] : 8'h00;
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_idx)
      REG_CTRL:   reg_rdata = ctrl_q;
      REG_STATUS: begin
        reg_rdata[STAT_BUSY] = busy;
        reg_rdata[STAT_DONE] = done_q;
      end
      REG_RESULT: reg_rdata = result_q;
      default:    reg_rdata = '0;
    endcase
  end

  // Evaluation completion takes priority over a same-cycle W1C
  assign done_set = (state_q == ST_EVWAIT);
  assign done_clr = (state_q == ST_IDLE) && req && is_reg && wbs_we_i &&
                    (reg_idx == REG_STATUS) && wbs_dat_i[STAT_DONE];
  assign done_d   = done_set | (done_q & ~done_clr);

  sram_imc_settle_cnt #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .load_i ((state_q == ST_ACK) && start_pend_q),
    .en_i   (state_q == ST_SETTLE),
    .done_o (settle_done)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      start_pend_q <= 1'b0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      en_vclp_q    <= 1'b0;
    end else begin
      // strobes and the ack/data pair are single-cycle by default
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      done_q   <= done_d;
      case (state_q)
        ST_IDLE: if (req) begin
          if (is_reg) begin
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
            if (wbs_we_i) begin
              if (reg_idx == REG_CTRL) begin
                ctrl_q       <= wbs_dat_i & CTRL_MASK;
                start_pend_q <= wbs_dat_i[CTRL_START] & ~busy;
              end
            end else begin
              dat_q <= reg_rdata;
            end
          end else begin
            mem_addr_q <= row;
            if (wbs_we_i) begin
              mem_wdata_q <= wmerge;
              mem_we_q    <= 1'b1;
              state_q     <= ST_WRITE;
            end else begin
              mem_re_q <= 1'b1;
              state_q  <= ST_READ;
            end
          end
        end
        // an abandoned cycle still finishes the macro access but gets no ack
        ST_WRITE: begin
          ack_q   <= live;
          state_q <= ST_ACK;
        end
        ST_READ: state_q <= ST_RDWAIT;
        ST_RDWAIT: begin
          ack_q   <= live;
          if (live) dat_q <= mem_rdata;
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (start_pend_q) begin
            start_pend_q <= 1'b0;
            en_vclp_q    <= 1'b1;
            state_q      <= ST_SETTLE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETTLE: if (settle_done) begin
          mem_re_q   <= 1'b1;
          mem_addr_q <= ctrl_q[CTRL_ROW_LSB +: ADDR_W];
          state_q    <= ST_EVAL;
        end
        ST_EVAL: state_q <= ST_EVWAIT;
        ST_EVWAIT: begin
          result_q  <= mem_rdata;
          en_vclp_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign en_vclp   = en_vclp_q;
  assign iref_en   = ctrl_q[CTRL_IREF_LSB +: N_IREF];
  assign imc_irq   = done_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_sram_imc_wb_ctrl.sv
// Directed bench for sram_imc_wb_ctrl with a behavioural macro and a
// spec-level register/memory model checked every cycle.
module tb_sram_imc_wb_ctrl;

  localparam int          SETTLE = 4;
  localparam logic [31:0] DBASE  = 32'h3000_0000;
  localparam logic [31:0] RBASE  = 32'h3001_0000;

  logic        clk, rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re, en_vclp, imc_irq;
  logic [3:0]  iref_en;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // macro emulation and spec model state
  logic [31:0] mem_arr [256];
  logic [31:0] m_mem   [256];
  logic [31:0] m_ctrl, m_result;
  bit          m_done;

  sram_imc_wb_ctrl #(
    .DATA_W(32), .ADDR_W(8), .N_IREF(4), .SETTLE_CYC(SETTLE), .BASE_ADDR(DBASE)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .en_vclp(en_vclp), .iref_en(iref_en), .imc_irq(imc_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // macro: write on mem_we, read data one cycle after mem_re, garbage otherwise
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    mem_rdata <= mem_re ? mem_arr[mem_addr] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? d[b*8 +: 8] : 8'h00;
    return m;
  endfunction

  // every-cycle compare against the model
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      if (!ack) chk("dat_o_idle", dat_o, 32'h0);
      chk("imc_irq", 32'(imc_irq), 32'(m_ctrl[1] & m_done));
      chk("iref_en", 32'(iref_en), 32'(m_ctrl[11:8]));
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int exp_lat, output logic [31:0] rd);
    int n;
    bit got;
    logic [31:0] mw;
    mw = merge(d, s);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    n = 0; got = 0;
    while (!got && n < 64) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!a[16] && n == exp_lat - (w ? 1 : 2)) begin
        chk(w ? "mem_we" : "mem_re", 32'(w ? mem_we : mem_re), 32'h1);
        chk("mem_addr", 32'(mem_addr), 32'(a[9:2]));
        if (w) chk("mem_wdata", mem_wdata, mw);
      end
      if (ack) got = 1;
    end
    chk("ack_latency", 32'(n), 32'(exp_lat));
    rd = dat_o;
    cyc = 0; stb = 0; we = 0;
    if (got && w) begin
      if (!a[16]) m_mem[a[9:2]] = mw;
      else if (a[3:2] == 2'd0) m_ctrl = d & 32'h00FF_0F02;
      else if (a[3:2] == 2'd1 && d[1]) m_done = 0;
    end
  endtask

  // follow one evaluation from the START ack to DONE
  task automatic imc_watch(input logic [7:0] r);
    int cnt;
    bit seen;
    cnt = 0; seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (mem_re) seen = 1;
      else if (en_vclp) cnt++;
    end
    chk("eval_seen", 32'(seen), 32'h1);
    chk("settle_len", 32'(cnt), 32'(SETTLE));
    chk("eval_vclp", 32'(en_vclp), 32'h1);
    chk("eval_addr", 32'(mem_addr), 32'(r));
    @(posedge clk); @(posedge clk); #1;
    m_done = 1; m_result = m_mem[r];
    @(negedge clk);
    chk("vclp_off", 32'(en_vclp), 32'h0);
  endtask

  logic [31:0] rd, rd2;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 32'hA500_0000 | i;
      m_mem[i]   = 32'hA500_0000 | i;
    end
    m_ctrl = 0; m_done = 0; m_result = 0;
    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);          chk("rst_dat", dat_o, 0);
    chk("rst_we", 32'(mem_we), 0);        chk("rst_re", 32'(mem_re), 0);
    chk("rst_vclp", 32'(en_vclp), 0);     chk("rst_irq", 32'(imc_irq), 0);
    chk("rst_iref", 32'(iref_en), 0);     chk("rst_maddr", 32'(mem_addr), 0);
    chk("rst_mwdata", mem_wdata, 0);
    @(posedge clk); #1 rst = 0; chk_on = 1;

    for (int k = 0; k < 4; k++) begin
      wb_xfer(0, RBASE | (k << 2), 0, 4'hF, 1, rd);
      chk("reg_after_rst", rd, 32'h0);
    end

    // full-word write/read
    wb_xfer(1, DBASE | (5 << 2), 32'hDEADBEEF, 4'hF, 2, rd);
    wb_xfer(0, DBASE | (5 << 2), 0, 4'hF, 3, rd);
    chk("rd_row5", rd, 32'hDEADBEEF);
    // partial byte enables merge over zero
    wb_xfer(1, DBASE | (7 << 2), 32'h12345678, 4'b0011, 2, rd);
    wb_xfer(0, DBASE | (7 << 2), 0, 4'hF, 3, rd);
    chk("rd_row7", rd, 32'h00005678);
    wb_xfer(1, DBASE | (2 << 2), 32'hAABBCCDD, 4'b1100, 2, rd);
    wb_xfer(0, DBASE | (2 << 2), 0, 4'hF, 3, rd);
    chk("rd_row2", rd, m_mem[2]);

    // reserved register and CTRL field masking
    wb_xfer(1, RBASE | 12, 32'hFFFF_FFFF, 4'hF, 1, rd);
    wb_xfer(0, RBASE | 12, 0, 4'hF, 1, rd);
    chk("rsvd_rd", rd, 32'h0);
    wb_xfer(1, RBASE, 32'hFFFF_FFFE, 4'hF, 1, rd);
    wb_xfer(0, RBASE, 0, 4'hF, 1, rd);
    chk("ctrl_rd", rd, 32'h00FF_0F02);
    chk("ctrl_model", rd, m_ctrl);

    // IMC on row 3
    wb_xfer(1, RBASE, 32'h0003_0F03, 4'hF, 1, rd);
    imc_watch(8'd3);
    wb_xfer(0, RBASE | 8, 0, 4'hF, 1, rd);
    chk("result", rd, 32'hA500_0003);
    chk("result_model", rd, m_result);
    wb_xfer(0, RBASE | 4, 0, 4'hF, 1, rd);
    chk("status_done", rd, 32'h2);
    chk("irq_high", 32'(imc_irq), 32'h1);
    wb_xfer(1, RBASE | 4, 32'h2, 4'hF, 1, rd);
    wb_xfer(0, RBASE | 4, 0, 4'hF, 1, rd);
    chk("status_clr", rd, 32'h0);

    // data read stalls behind an IMC on row 5
    wb_xfer(1, RBASE, 32'h0005_0003, 4'hF, 1, rd);
    fork
      wb_xfer(0, DBASE | (5 << 2), 0, 4'hF, SETTLE + 5, rd2);
      imc_watch(8'd5);
    join
    chk("stall_rd", rd2, 32'hDEADBEEF);
    wb_xfer(0, RBASE | 8, 0, 4'hF, 1, rd);
    chk("stall_result", rd, m_result);

    // cycle abandoned mid-write: write lands, no ack
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = DBASE | (9 << 2); dat_i = 32'hCAFEF00D; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    m_mem[9] = 32'hCAFEF00D;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_noack", 32'(ack), 32'h0);
    end
    wb_xfer(0, DBASE | (9 << 2), 0, 4'hF, 3, rd);
    chk("abort_rd", rd, 32'hCAFEF00D);

    // foreign address is ignored
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 32'h2000_0000; dat_i = 32'h1; sel = 4'hF;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("unsel_ack", 32'(ack), 0);
      chk("unsel_we", 32'(mem_we), 0);
      chk("unsel_re", 32'(mem_re), 0);
    end
    cyc = 0; stb = 0; we = 0;

    // reset in the second settle cycle
    wb_xfer(1, RBASE, 32'h0003_0F03, 4'hF, 1, rd);
    @(negedge clk);
    @(negedge clk);
    chk("settle2_vclp", 32'(en_vclp), 32'h1);
    rst = 1; chk_on = 0;
    @(negedge clk);
    chk("rst_mid_vclp", 32'(en_vclp), 32'h0);
    @(posedge clk); #1;
    rst = 0; m_ctrl = 0; m_done = 0; m_result = 0; chk_on = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_eval", 32'(mem_re), 32'h0);
    end
    wb_xfer(0, RBASE | 4, 0, 4'hF, 1, rd);
    chk("rst_status", rd, 32'h0);
    wb_xfer(0, RBASE | 8, 0, 4'hF, 1, rd);
    chk("rst_result", rd, 32'h0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
